// File: rtl/mtl1_uart_pkg.sv
// Shared definitions for the 6809 terminal UART transmit path.
package mtl1_uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 69;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/count.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_n, rd_ptr_n, count_n;
  logic             push_ok, pop_ok;

  // A pop frees the slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign wr_ptr_n = push_ok ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_ptr_n = pop_ok  ? rd_ptr + 1'b1 : rd_ptr;
  assign count_n  = wr_ptr_n - rd_ptr_n;
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      full   <= (count_n == (AW+1)'(DEPTH));
      empty  <= (count_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= data;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 6809 UART transmit path: write-strobe capture, byte FIFO and 8N1 serializer.
//   state    | meaning
//   TX_IDLE  | line high, waiting for a queued byte
//   TX_START | start bit (low)
//   TX_DATA  | data bits, LSB first
//   TX_STOP  | stop bit (high), may chain directly into the next start bit
import mtl1_uart_pkg::*;

module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr_req,
  input  logic [7:0] i_wr_data,
  output logic       o_UART_RX,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic [4:0] o_count,
  output logic       o_overrun,
  input  logic       i_clr_overrun
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

  logic        wr_sync0, wr_sync1, wr_prev;
  logic        push_req, pop;
  logic [7:0]  fifo_head;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  tx_state_e   state;
  logic [BW-1:0] baud_cnt;
  logic [IW-1:0] bit_idx;
  logic [7:0]  shift_reg;
  logic        baud_done;

  // i_wr_req is asynchronous; i_wr_data is stable for the whole strobe, so it
  // can be taken directly on the detected edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sync0 <= 1'b0;
      wr_sync1 <= 1'b0;
      wr_prev  <= 1'b0;
    end else begin
      wr_sync0 <= i_wr_req;
      wr_sync1 <= wr_sync0;
      wr_prev  <= wr_sync1;
    end
  end

  assign push_req  = wr_sync1 && !wr_prev;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign pop       = !fifo_empty &&
                     ((state == TX_IDLE) || ((state == TX_STOP) && baud_done));

  uart_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .data  (i_wr_data),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;
  assign o_count = 5'(fifo_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_overrun <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      o_overrun <= 1'b1;
    end else if (i_clr_overrun) begin
      o_overrun <= 1'b0;
    end
  end

  // The line register follows the state one cycle later, so every bit still
  // lasts exactly CLKS_PER_BIT cycles and busy drops as the stop bit ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= TX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      o_UART_RX <= 1'b1;
      o_busy    <= 1'b0;
    end else begin
      unique case (state)
        TX_START: o_UART_RX <= 1'b0;
        TX_DATA:  o_UART_RX <= shift_reg[0];
        default:  o_UART_RX <= 1'b1;
      endcase
      o_busy <= (state != TX_IDLE) || !fifo_empty;

      unique case (state)
        TX_IDLE: begin
          if (pop) begin
            shift_reg <= fifo_head;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            state     <= TX_START;
          end
        end
        TX_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= TX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_done) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_idx == BIT_LAST) begin
              state <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_reg <= fifo_head;
              bit_idx   <= '0;
              state     <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit path of the 6809 terminal UART. It accepts bytes that the 6809 writes to the UART data register and buffers them in an 8-entry FIFO. It serializes them as 8N1 frames onto the FT2232 UART receive line. It sits directly downstream of `uart_interface`, consumes its transmit data and write qualifier, and returns FIFO status bits for the UART status register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 69: `clk` cycles per bit (8 MHz / 115200 baud). Legal range 4–1023.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two, 2–16.

Ports:
- `clk`, input, 1: 8 MHz system clock (PLL `CLKOS`). This is the block's only clock.
- `reset`, input, 1: synchronous, active-high reset.
- `i_wr_req`, input, 1: write qualifier from the 6809 bus (uart_data_ce && !RW && E). Asynchronous to `clk`. Held high for many `clk` cycles per bus write.
- `i_wr_data`, input, 8: byte to send. Stable for the whole time `i_wr_req` is high.
- `o_UART_RX`, output, 1: serial line to the FT2232 RXD pin. Idle level is high.
- `o_full`, output, 1: FIFO holds `FIFO_DEPTH` entries.
- `o_empty`, output, 1: FIFO holds 0 entries.
- `o_busy`, output, 1: a frame is in progress, or the FIFO is non-empty.
- `o_count`, output, 5: current FIFO occupancy.
- `o_overrun`, output, 1: sticky flag. Set when a write arrives while the FIFO is full. Cleared by `reset` or `i_clr_overrun`.
- `i_clr_overrun`, input, 1: one-cycle clear for `o_overrun`.

## Operation
Write capture:
- `i_wr_req` passes through a 2-flop synchronizer, then a rising-edge detector.
- Each bus write produces exactly one push, however long `i_wr_req` stays high.
- On the detected edge cycle, `i_wr_data` is sampled directly. It is already stable because it is valid across the whole E-high window.
- Push while full: the byte is dropped, `o_overrun` is set, and the FIFO is unchanged.
- Push and pop in the same cycle: both take effect and `o_count` is unchanged. This is legal even when the FIFO is full, because the pop frees a slot in that cycle and the push is accepted.
- Pointers are `$clog2(FIFO_DEPTH)` bits wide, wrap modulo depth, and use an extra wrap bit for full/empty.

Transmit FSM, states IDLE, START, DATA, STOP:
- IDLE: `o_UART_RX`=1. If the FIFO is non-empty, pop the head byte into the shift register, clear the bit counter, and go to START.
- START: `o_UART_RX`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: drive the shift register LSB for `CLKS_PER_BIT` cycles, then shift right. After 8 bits go to STOP.
- STOP: `o_UART_RX`=1 for `CLKS_PER_BIT` cycles. Then go to IDLE, or, if the FIFO is non-empty, pop and go straight to START. There is no idle gap between queued frames.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It counts 0 to `CLKS_PER_BIT`-1 and reloads 0 on every state or bit change.

Reset:
- Any cycle with `reset`=1 aborts the current frame and forces IDLE.
- The FIFO is emptied and the synchronizer and edge-detect registers are cleared. A write held high across reset release therefore produces no push.
- A frame truncated by reset is not retransmitted.

## Timing
- Reset values: `o_UART_RX`=1, `o_full`=0, `o_empty`=1, `o_busy`=0, `o_count`=0, `o_overrun`=0.
- All outputs are registered.
- Write latency: the push is visible in `o_count` 3 `clk` cycles after `i_wr_req` rises (2 synchronizer cycles plus 1 edge/push cycle).
- Start-bit latency: from an empty FIFO, `o_UART_RX` falls 2 cycles after the push (IDLE pop cycle plus the registered output).
- Frame length: exactly 10 × `CLKS_PER_BIT` cycles.
- Back-to-back frames: stop bit of frame N is followed immediately by start bit of frame N+1.
- Status updates: `o_full`, `o_empty` and `o_count` update in the cycle after the push or pop. `o_busy` falls in the cycle after STOP completes with an empty FIFO.

## Structure
- Shared package `mtl1_uart_pkg`:
  - state encoding typedef (IDLE/START/DATA/STOP);
  - `UART_DATA_BITS`=8;
  - `UART_DEFAULT_CLKS_PER_BIT`=69.
- Sub-module `uart_sync_fifo` (parameters width and depth):
  - inputs push/pop/data;
  - outputs head data, full, empty, count;
  - read is first-word-fall-through, so the head byte is valid while not empty.
- The serializer FSM, synchronizer and edge detector live in `uart_tx_serializer` itself.

## Test plan
1. Reset, then idle: `o_UART_RX`=1 and `o_empty`=1 for 1000 cycles.
2. Single write of 0x55 with `CLKS_PER_BIT`=4:
   - line reads start 0, bits 1,0,1,0,1,0,1,0, stop 1, each held 4 cycles;
   - frame lasts 40 cycles.
3. Long `i_wr_req` pulse (200 cycles) carrying 0xA3 → exactly one frame sent and `o_count` peaks at 1.
4. Nine writes 0x00–0x08 issued faster than one frame:
   - first byte already popped → 8 stored, no overrun;
   - tenth write while full sets `o_overrun`;
   - serial output is bytes 0x00–0x08 in order, with no gaps between frames;
   - `i_clr_overrun` clears the flag.
5. Reset asserted mid DATA bit 3 of 0xFF with 3 bytes queued → `o_UART_RX`=1 the next cycle, `o_count`=0, nothing sent afterwards.
6. Push coinciding with a STOP-end pop while full → `o_count` stays at 8 and no overrun.
